// File: rtl/execute_multicycle.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative shift-add multiplier, flags, E/M register.
// Optional build macro EXEC_MUL_EARLY_TERM_EN: the multiply stops as soon as the remaining multiplier is zero.
module execute_multicycle #(
    parameter int N  = 24,
    parameter int RW = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  RD1E,
    input  logic [N-1:0]  RD2E,
    input  logic [N-1:0]  ExtImmE,
    input  logic [N-1:0]  ResultW,
    input  logic [N-1:0]  ALUResultMFB,
    input  logic [1:0]    ForwardAE,
    input  logic [1:0]    ForwardBE,
    input  logic          ALUSrcE,
    input  logic [3:0]    ALUControlE,
    input  logic          ValidE,
    input  logic          FlushE,
    input  logic          RegWriteE,
    input  logic          MemWriteE,
    input  logic          MemtoRegE,
    input  logic          BranchE,
    input  logic          FlagWriteE,
    input  logic [2:0]    CondE,
    input  logic [3:0]    FlagsE,
    input  logic [RW-1:0] WA3E,
    output logic          StallE,
    output logic          BranchTakenE,
    output logic [N-1:0]  BranchTargetE,
    output logic [3:0]    FlagsNextE,
    output logic          ValidM,
    output logic          RegWriteM,
    output logic          MemWriteM,
    output logic          MemtoRegM,
    output logic [N-1:0]  ALUResultM,
    output logic [N-1:0]  WriteDataM,
    output logic [RW-1:0] WA3M
);
    localparam int SW = $clog2(N);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_MULH = 4'd9;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [N-1:0]   src_a;
    logic [N-1:0]   src_b;
    logic [N-1:0]   write_data_e;
    logic [N:0]     add_full;
    logic [N:0]     sub_full;
    logic           v_add;
    logic           v_sub;
    logic [SW-1:0]  shamt;
    logic [N-1:0]   alu_result;
    logic [N-1:0]   mul_result;
    logic [N-1:0]   exec_result;
    logic [3:0]     flags_upd;
    logic           cond_pass;
    logic           fire;
    logic           issue;

    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           mul_hi;
    logic [2*N-1:0] acc_step;
    logic [N-1:0]   mplier_shift;
    logic           last_iter;

    function automatic logic [N-1:0] fwd(input logic [1:0] sel, input logic [N-1:0] rd,
                                         input logic [N-1:0] res_w, input logic [N-1:0] alu_m);
        case (sel)
            2'b00:   fwd = rd;
            2'b01:   fwd = res_w;
            2'b10:   fwd = alu_m;
            default: fwd = '1;
        endcase
    endfunction

    assign src_a        = fwd(ForwardAE, RD1E, ResultW, ALUResultMFB);
    assign write_data_e = fwd(ForwardBE, RD2E, ResultW, ALUResultMFB);
    assign src_b        = ALUSrcE ? ExtImmE : write_data_e;
    assign shamt        = src_b[SW-1:0];

    // Subtraction as a + ~b + 1 so the carry-out reads directly as "no borrow".
    assign add_full = {1'b0, src_a} + {1'b0, src_b};
    assign sub_full = {1'b0, src_a} + {1'b0, ~src_b} + (N+1)'(1);
    assign v_add    = (src_a[N-1] == src_b[N-1]) && (add_full[N-1] != src_a[N-1]);
    assign v_sub    = (src_a[N-1] != src_b[N-1]) && (sub_full[N-1] != src_a[N-1]);

    always_comb begin
        alu_result = src_b;
        case (ALUControlE)
            OP_ADD:  alu_result = add_full[N-1:0];
            OP_SUB:  alu_result = sub_full[N-1:0];
            OP_AND:  alu_result = src_a & src_b;
            OP_OR:   alu_result = src_a | src_b;
            OP_XOR:  alu_result = src_a ^ src_b;
            OP_SLL:  alu_result = src_a << shamt;
            OP_SRL:  alu_result = src_a >> shamt;
            default: alu_result = src_b;
        endcase
    end

    assign mul_result = mul_hi ? acc[2*N-1:N] : acc[N-1:0];

    always_comb begin
        exec_result = (state == DONE) ? mul_result : alu_result;
        flags_upd   = {exec_result[N-1], exec_result == '0, FlagsE[1:0]};
        if (state != DONE) begin
            if (ALUControlE == OP_ADD)
                flags_upd[1:0] = {add_full[N], v_add};
            else if (ALUControlE == OP_SUB)
                flags_upd[1:0] = {sub_full[N], v_sub};
        end
    end

    always_comb begin
        cond_pass = 1'b0;
        case (CondE)
            3'b000:  cond_pass = 1'b1;
            3'b001:  cond_pass = FlagsE[2];
            3'b010:  cond_pass = !FlagsE[2];
            3'b011:  cond_pass = FlagsE[3] ^ FlagsE[0];
            3'b100:  cond_pass = !(FlagsE[3] ^ FlagsE[0]);
            3'b101:  cond_pass = !FlagsE[2] && (FlagsE[3] == FlagsE[0]);
            3'b110:  cond_pass = FlagsE[2] || (FlagsE[3] ^ FlagsE[0]);
            default: cond_pass = 1'b0;
        endcase
    end

    assign issue         = (state == IDLE) && ValidE && !FlushE &&
                           ((ALUControlE == OP_MUL) || (ALUControlE == OP_MULH));
    assign StallE        = issue || (state == RUN);
    assign fire          = ValidE && cond_pass && !StallE && !FlushE;
    assign FlagsNextE    = (fire && FlagWriteE) ? flags_upd : FlagsE;
    assign BranchTakenE  = fire && BranchE;
    assign BranchTargetE = ExtImmE;

    assign acc_step     = mplier[0] ? acc + mcand : acc;
    assign mplier_shift = mplier >> 1;
`ifdef EXEC_MUL_EARLY_TERM_EN
    assign last_iter    = (cnt == CW'(N - 1)) || (mplier_shift == '0);
`else
    assign last_iter    = (cnt == CW'(N - 1));
`endif

    // Operands are latched at issue, so forwarding sources may change freely while RUN iterates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            mul_hi <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state  <= RUN;
                        mcand  <= {{N{1'b0}}, src_a};
                        mplier <= src_b;
                        acc    <= '0;
                        cnt    <= '0;
                        mul_hi <= (ALUControlE == OP_MULH);
                    end
                end
                RUN: begin
                    if (FlushE) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_step;
                        mcand  <= mcand << 1;
                        mplier <= mplier_shift;
                        cnt    <= cnt + CW'(1);
                        if (last_iter)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // In DONE the upstream registers still hold the multiply, so its controls are used as-is.
    always_ff @(posedge clk) begin
        if (rst || StallE || FlushE) begin
            ValidM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
        end else begin
            ValidM     <= ValidE;
            RegWriteM  <= ValidE && cond_pass && RegWriteE;
            MemWriteM  <= ValidE && cond_pass && MemWriteE;
            MemtoRegM  <= ValidE && MemtoRegE;
            ALUResultM <= exec_result;
            WriteDataM <= write_data_e;
            WA3M       <= WA3E;
        end
    end
endmodule

// File: tb/tb_execute_multicycle.sv
// Self-checking bench for execute_multicycle: scoreboard of expected M-stage results plus directed timing checks.
module tb_execute_multicycle;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] RD1E, RD2E, ExtImmE, ResultW, ALUResultMFB;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        ALUSrcE;
    logic [3:0]  ALUControlE;
    logic        ValidE, FlushE, RegWriteE, MemWriteE, MemtoRegE, BranchE, FlagWriteE;
    logic [2:0]  CondE;
    logic [3:0]  FlagsE;
    logic [3:0]  WA3E;
    logic        StallE, BranchTakenE;
    logic [23:0] BranchTargetE;
    logic [3:0]  FlagsNextE;
    logic        ValidM, RegWriteM, MemWriteM, MemtoRegM;
    logic [23:0] ALUResultM, WriteDataM;
    logic [3:0]  WA3M;

    typedef struct packed {
        logic [23:0] res;
        logic        rw;
        logic        mw;
        logic [3:0]  wa;
        logic [23:0] wd;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   expect_valid = 1'b0;

    execute_multicycle #(.N(24), .RW(4)) dut (
        .clk(clk), .rst(rst),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
        .ResultW(ResultW), .ALUResultMFB(ALUResultMFB),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .ValidE(ValidE), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .BranchE(BranchE), .FlagWriteE(FlagWriteE),
        .CondE(CondE), .FlagsE(FlagsE), .WA3E(WA3E),
        .StallE(StallE), .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
        .FlagsNextE(FlagsNextE),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] fwd_model(input logic [1:0] sel, input logic [23:0] rd,
                                              input logic [23:0] rw, input logic [23:0] am);
        if (sel == 2'd0) return rd;
        if (sel == 2'd1) return rw;
        if (sel == 2'd2) return am;
        return 24'hFFFFFF;
    endfunction

    function automatic logic [23:0] model_alu(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
        longint p;
        int     sh;
        p  = longint'(a) * longint'(b);
        sh = int'(b[4:0]);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return (sh >= 24) ? 24'h0 : (a << sh);
            4'd6: return (sh >= 24) ? 24'h0 : (a >> sh);
            4'd8: return p[23:0];
            4'd9: return p[47:24];
            default: return b;
        endcase
    endfunction

    function automatic logic [3:0] model_flags(input logic [3:0] op, input logic [23:0] a,
                                               input logic [23:0] b, input logic [3:0] fin);
        logic [23:0] r;
        logic        c, v;
        longint      ua, ub;
        int          sa, sb, s;
        r  = model_alu(op, a, b);
        c  = fin[1];
        v  = fin[0];
        ua = longint'(a);
        ub = longint'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (op == 4'd0) begin
            c = (ua + ub) > 16777215;
            s = sa + sb;
            v = (s > 8388607) || (s < -8388608);
        end else if (op == 4'd1) begin
            c = (ua >= ub);
            s = sa - sb;
            v = (s > 8388607) || (s < -8388608);
        end
        return {r[23], r == 24'h0, c, v};
    endfunction

    function automatic logic cond_model(input logic [2:0] cc, input logic [3:0] f);
        logic n, z, v;
        n = f[3];
        z = f[2];
        v = f[0];
        case (cc)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n != v;
            3'd4: return n == v;
            3'd5: return !z && (n == v);
            3'd6: return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int run_len(input logic [23:0] b);
        int l;
        l = 24;
`ifdef EXEC_MUL_EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < 24; i++)
            if (b[i]) l = i + 1;
`endif
        return l;
    endfunction

    task automatic applyIdle();
        ValidE = 1'b0; FlushE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0; MemtoRegE = 1'b0;
        BranchE = 1'b0; FlagWriteE = 1'b0; ALUControlE = 4'd0; ALUSrcE = 1'b0;
        ForwardAE = 2'd0; ForwardBE = 2'd0; CondE = 3'd0; FlagsE = 4'd0; WA3E = 4'd0;
        RD1E = 24'h0; RD2E = 24'h0; ExtImmE = 24'h0;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                                 input logic use_imm, input logic [2:0] cc, input logic [3:0] flags,
                                 input logic [3:0] wa);
        ALUControlE = op; RD1E = a; ALUSrcE = use_imm;
        if (use_imm) begin
            ExtImmE = b; RD2E = 24'($urandom);
        end else begin
            RD2E = b; ExtImmE = 24'($urandom);
        end
        ForwardAE = 2'd0; ForwardBE = 2'd0; CondE = cc; FlagsE = flags; WA3E = wa;
        ValidE = 1'b1; FlushE = 1'b0; RegWriteE = 1'b1; MemWriteE = 1'b0; MemtoRegE = 1'b0;
        BranchE = 1'b0; FlagWriteE = 1'b1;
    endtask

    task automatic pushExpect(input logic [23:0] res, input logic rw, input logic mw,
                              input logic [3:0] wa, input logic [23:0] wd);
        exp_t e;
        e.res = res; e.rw = rw; e.mw = mw; e.wa = wa; e.wd = wd;
        sb_q.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Multiply issued now through the ResultW path; ResultW is scrambled after issue.
    task automatic doMul(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] exp_res, input logic [3:0] wa);
        int         l;
        logic [3:0] mflags;
        applyStimulus(op, 24'h0, b, 1'b0, 3'd0, 4'b0011, wa);
        ForwardAE = 2'd1;
        ResultW   = a;
        l         = run_len(b);
        mflags    = {exp_res[23], exp_res == 24'h0, 2'b11};
        pushExpect(exp_res, 1'b1, 1'b0, wa, b);
        for (int k = 0; k <= l + 1; k++) begin
            @(negedge clk);
            checkOutput("mul_stall", StallE, (k <= l) ? 1 : 0);
            if (k >= 1) checkOutput("mul_bubble", ValidM, 0);
            checkOutput("mul_flags", FlagsNextE, (k == l + 1) ? mflags : 4'b0011);
            nextCycle();
            ResultW = 24'($urandom);
        end
        expect_valid = 1'b1;
    endtask

    always @(negedge clk) begin
        if (expect_valid) begin
            checkOutput("mul_latency", ValidM, 1);
            expect_valid = 1'b0;
        end
        if (ValidM) begin
            checkOutput("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                checkOutput("sb_result", ALUResultM, mon_e.res);
                checkOutput("sb_regwrite", RegWriteM, mon_e.rw);
                checkOutput("sb_memwrite", MemWriteM, mon_e.mw);
                checkOutput("sb_wa3", WA3M, mon_e.wa);
                checkOutput("sb_writedata", WriteDataM, mon_e.wd);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd15};
        logic [3:0]  op;
        logic [23:0] sa, wd, sb;
        logic        pass;
        logic [23:0] ma, mb;

        rst = 1'b1;
        applyIdle();
        ResultW = 24'h0;
        ALUResultMFB = 24'h0;
        repeat (2) nextCycle();
        @(negedge clk);
        checkOutput("rst_stall", StallE, 0);
        checkOutput("rst_validm", ValidM, 0);
        checkOutput("rst_regwrite", RegWriteM, 0);
        checkOutput("rst_memwrite", MemWriteM, 0);
        checkOutput("rst_result", ALUResultM, 0);
        checkOutput("rst_wa3", WA3M, 0);
        nextCycle();
        rst = 1'b0;

        $display("[TB] directed ALU cases");
        applyStimulus(4'd0, 24'h7FFFFF, 24'h000001, 1'b0, 3'd0, 4'b0000, 4'd3);
        pushExpect(24'h800000, 1'b1, 1'b0, 4'd3, 24'h000001);
        @(negedge clk);
        checkOutput("add_flags", FlagsNextE, 4'b1001);
        checkOutput("add_stall", StallE, 0);
        nextCycle();

        applyStimulus(4'd1, 24'h0, 24'h000010, 1'b1, 3'd0, 4'b0000, 4'd5);
        ForwardAE = 2'd2;
        ALUResultMFB = 24'h000010;
        pushExpect(24'h0, 1'b1, 1'b0, 4'd5, RD2E);
        @(negedge clk);
        checkOutput("sub_flags", FlagsNextE, 4'b0110);
        nextCycle();

        applyStimulus(4'd0, 24'h1, 24'h2, 1'b0, 3'd1, 4'b0000, 4'd7);
        BranchE = 1'b1;
        ExtImmE = 24'hABCDEF;
        pushExpect(24'h3, 1'b0, 1'b0, 4'd7, 24'h2);
        @(negedge clk);
        checkOutput("eqfail_branch", BranchTakenE, 0);
        checkOutput("eqfail_flags", FlagsNextE, 4'b0000);
        checkOutput("branch_target", BranchTargetE, 24'hABCDEF);
        nextCycle();

        applyStimulus(4'd0, 24'h1, 24'h2, 1'b0, 3'd1, 4'b0100, 4'd8);
        BranchE = 1'b1;
        pushExpect(24'h3, 1'b1, 1'b0, 4'd8, 24'h2);
        @(negedge clk);
        checkOutput("eqpass_branch", BranchTakenE, 1);
        checkOutput("eqpass_flags", FlagsNextE, 4'b0000);
        nextCycle();

        $display("[TB] random single-cycle ops");
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 9)];
            applyStimulus(op, 24'($urandom), 24'($urandom), 1'($urandom), 3'($urandom),
                          4'($urandom), 4'($urandom));
            if (op == 4'd5 || op == 4'd6) begin
                if (ALUSrcE) ExtImmE = 24'($urandom_range(0, 31));
                else RD2E = 24'($urandom_range(0, 31));
            end
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            ResultW = 24'($urandom); ALUResultMFB = 24'($urandom);
            MemWriteE = 1'($urandom); BranchE = 1'($urandom); FlagWriteE = 1'($urandom);
            sa   = fwd_model(ForwardAE, RD1E, ResultW, ALUResultMFB);
            wd   = fwd_model(ForwardBE, RD2E, ResultW, ALUResultMFB);
            sb   = ALUSrcE ? ExtImmE : wd;
            pass = cond_model(CondE, FlagsE);
            pushExpect(model_alu(op, sa, sb), pass, MemWriteE & pass, WA3E, wd);
            @(negedge clk);
            checkOutput("rand_flags", FlagsNextE,
                        (FlagWriteE && pass) ? model_flags(op, sa, sb, FlagsE) : FlagsE);
            checkOutput("rand_branch", BranchTakenE, BranchE && pass);
            nextCycle();
        end

        $display("[TB] flush in IDLE");
        applyStimulus(4'd0, 24'h5, 24'h5, 1'b0, 3'd0, 4'b0101, 4'd2);
        FlushE = 1'b1;
        BranchE = 1'b1;
        @(negedge clk);
        checkOutput("flush_flags", FlagsNextE, 4'b0101);
        checkOutput("flush_branch", BranchTakenE, 0);
        nextCycle();
        applyIdle();
        @(negedge clk);
        checkOutput("flush_bubble", ValidM, 0);
        nextCycle();

        $display("[TB] multiplies, back-to-back");
        doMul(4'd8, 24'd5, 24'd3, 24'd15, 4'd9);
        doMul(4'd9, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 4'd10);
        doMul(4'd8, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 4'd11);
        ma = 24'($urandom);
        mb = 24'($urandom);
        doMul(4'd9, ma, mb, model_alu(4'd9, ma, mb), 4'd12);
        doMul(4'd8, ma, 24'h0, 24'h0, 4'd13);
        applyIdle();
        nextCycle();

        $display("[TB] reset during RUN");
        applyStimulus(4'd8, 24'h7, 24'hFFFFFF, 1'b0, 3'd0, 4'b0000, 4'd1);
        repeat (3) nextCycle();
        rst = 1'b1;
        applyIdle();
        nextCycle();
        @(negedge clk);
        checkOutput("rstrun_stall", StallE, 0);
        checkOutput("rstrun_validm", ValidM, 0);
        checkOutput("rstrun_regwrite", RegWriteM, 0);
        checkOutput("rstrun_result", ALUResultM, 0);
        rst = 1'b0;
        nextCycle();

        $display("[TB] flush during RUN");
        applyStimulus(4'd8, 24'h7, 24'hFFFFFF, 1'b0, 3'd0, 4'b0010, 4'd1);
        repeat (2) nextCycle();
        FlushE = 1'b1;
        @(negedge clk);
        checkOutput("flushrun_flags", FlagsNextE, 4'b0010);
        nextCycle();
        applyIdle();
        @(negedge clk);
        checkOutput("flushrun_stall", StallE, 0);
        checkOutput("flushrun_validm", ValidM, 0);
        nextCycle();
        applyStimulus(4'd2, 24'hF0F0F0, 24'h0FF0FF, 1'b0, 3'd0, 4'b0000, 4'd14);
        pushExpect(24'h00F0F0, 1'b1, 1'b0, 4'd14, 24'h0FF0FF);
        @(negedge clk);
        checkOutput("resume_stall", StallE, 0);
        nextCycle();
        applyIdle();
        repeat (3) nextCycle();

        checkOutput("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
